bnn_dot_acc: RTL and testbench
==============================

// Module: bnn_dot_acc
// PURPOSE
//  Multi-cycle binary-NN dot-product engine: streams N operand-word pairs and accumulates
//  popcount(~(A^B)) over all of them.
//  Successor to the single-word XNOR-popcount execute unit; generalised to LANES words/beat
//  and a programmable vector length.
//  Sits beside the ALU as a custom-instruction coprocessor; the core starts it, feeds
//  operand beats, then reads back one result.
// PARAMETERS
//  XLEN      32   bits per operand word
//  LANES     1    words per operand per beat (1..8)
//  MAX_WORDS 64   max beats per job (len_i upper bound)
//  CNT_W     $clog2(MAX_WORDS+1)            beat-count width (derived)
//  ACC_W     $clog2(MAX_WORDS*LANES*XLEN+1) accumulator width (derived, never overflows)
// PORTS
//  clk          in   1             clock, rising edge
//  reset_n      in   1             async active-low reset
//  start_i      in   1             start job; sampled only in IDLE
//  len_i        in   CNT_W         beats in job, sampled with start_i
//  busy_o       out  1             1 when state != IDLE
//  in_valid_i   in   1             operand beat valid
//  in_ready_o   out  1             engine accepts beat (RUN only)
//  op_a_i       in   XLEN*LANES    activations, lane k = bits[k*XLEN +: XLEN]
//  op_b_i       in   XLEN*LANES    weights, same packing
//  res_valid_o  out  1             result valid (DONE)
//  res_ready_i  in   1             consumer takes result
//  res_o        out  ACC_W         accumulated XNOR-popcount
//  thresh_i     in   ACC_W         activation threshold (BNN_THRESH_EN only)
//  act_o        out  1             binarised activation (BNN_THRESH_EN only)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, acc=0, beat count=0; outputs busy_o=0,
//    in_ready_o=0, res_valid_o=0, res_o=0, act_o=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: start_i=1 latches len_i and clears acc.
//    len_i>=1 -> RUN; len_i==0 -> DONE with res_o=0.
//    len_i>MAX_WORDS is clamped to MAX_WORDS.
//  - RUN: in_ready_o=1. A beat transfers when in_valid_i&&in_ready_o.
//    On transfer, acc += sum over lanes of popcount(~(a_k^b_k)) (combinational) and
//    count++. The transfer of beat number len moves the FSM to DONE.
//    No gaps are required; one beat per cycle is sustained.
//  - DONE: res_valid_o=1, in_ready_o=0, res_o=acc held stable.
//    res_ready_i=1 -> IDLE next cycle, with res_valid_o=0 in that cycle.
//    Back-pressure holds DONE indefinitely.
//  - Latency: res_valid_o rises the cycle after the last beat's transfer edge;
//    len=N beats at full rate -> result valid N+1 cycles after start.
//  - start_i outside IDLE is ignored; there is no queuing.
//    A start_i asserted in the same cycle as the DONE handshake is also ignored.
//  - in_valid_i outside RUN is ignored; no transfer occurs.
//  - Operand values are don't-care when in_valid_i=0.
//  - Max result = MAX_WORDS*LANES*XLEN, which fits ACC_W; no wrap or saturation logic.
//  - Reset asserted mid-job aborts immediately; the partial acc is discarded.
// CONFIGURATION
//  BNN_THRESH_EN defined:
//    - Ports thresh_i/act_o exist. thresh_i is sampled with start_i.
//    - act_o = (acc >= thresh), valid and held with res_valid_o; act_o=0 otherwise.
//  BNN_THRESH_EN undefined:
//    - thresh_i/act_o are absent; no comparator logic.
//    - All other behaviour is identical.
// TESTING
//  1. LANES=1, start len=1, A=B=32'h0 -> res_o=32 at cycle 2 after start; busy_o falls
//     after the handshake.
//  2. len=4, beats A=FFFF_FFFF/B=0, A=B=FFFF_FFFF, A=0F0F_0F0F/B=0, A=0/B=0
//     -> res_o = 0+32+16+32 = 80.
//  3. len=3 with in_valid_i toggling 1,0,0,1,1 -> exactly 3 transfers, res_o correct.
//     Hold res_ready_i=0 for 5 cycles -> res_o stable and in_ready_o=0.
//  4. len=0 -> DONE next cycle with res_o=0.
//     start_i during RUN and DONE -> ignored, len unchanged.
//  5. len=MAX_WORDS with all beats equal -> res_o=MAX_WORDS*LANES*XLEN, no wrap.
//     Repeat with LANES=4.
//  6. reset_n low mid-RUN after 2 beats -> all outputs 0 at once.
//     A new len=1 job then returns the correct fresh value.
//     With BNN_THRESH_EN and thresh=40: case-2 data gives act_o=1; thresh=81 gives act_o=0.

Source files
------------

// File: rtl/bnn_dot_acc.sv
// bnn_dot_acc: multi-cycle binary-NN dot-product engine.
// Streams len operand beats of LANES words each and accumulates popcount(~(a ^ b)).
// Optional feature: define BNN_THRESH_EN to add thresh_i/act_o (result >= threshold).
module bnn_dot_acc #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LANES     = 1,
  parameter int unsigned MAX_WORDS = 64,
  localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1),
  localparam int unsigned ACC_W    = $clog2(MAX_WORDS * LANES * XLEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      len_i,
  output logic                  busy_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [XLEN*LANES-1:0] op_a_i,
  input  logic [XLEN*LANES-1:0] op_b_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
`ifdef BNN_THRESH_EN
  input  logic [ACC_W-1:0]      thresh_i,
  output logic                  act_o,
`endif
  output logic [ACC_W-1:0]      res_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   len_clamp;
  logic [XLEN*LANES-1:0] match;
  logic [ACC_W-1:0]   beat_pop;

  // Oversized requests run the longest supported job rather than wrapping.
  assign len_clamp = (len_i > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : len_i;
  assign match     = ~(op_a_i ^ op_b_i);

  // Popcount of all lanes at once; the per-lane sum is the same total.
  always_comb begin
    beat_pop = '0;
    for (int unsigned i = 0; i < XLEN * LANES; i++) begin
      beat_pop = beat_pop + ACC_W'(match[i]);
    end
  end

`ifdef BNN_THRESH_EN
  logic [ACC_W-1:0] thresh_q;

  // Threshold is captured with the job so it cannot change under a pending result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thresh_q <= '0;
    end else if (state_q == StIdle && start_i) begin
      thresh_q <= thresh_i;
    end
  end

  assign act_o = (state_q == StDone) && (acc_q >= thresh_q);
`endif

  // Job sequencing: latch length, accumulate accepted beats, hold result until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q   <= len_clamp;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= (len_clamp == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (in_valid_i) begin
            acc_q <= acc_q + beat_pop;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == len_q) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (res_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign in_ready_o  = (state_q == StRun);
  assign res_valid_o = (state_q == StDone);
  assign res_o       = acc_q;

endmodule

// File: tb/tb_bnn_dot_acc.sv
// Bench for bnn_dot_acc: directed jobs, expected results queued at issue time and
// checked by monitor processes on each result handshake.
module tb_bnn_dot_acc;
  localparam int XLEN   = 32;
  localparam int LANES  = 1;
  localparam int MAXW   = 64;
  localparam int CNT_W  = $clog2(MAXW + 1);
  localparam int ACC_W  = $clog2(MAXW * LANES * XLEN + 1);
  localparam int L4     = 4;
  localparam int MAXW4  = 8;
  localparam int CNT_W4 = $clog2(MAXW4 + 1);
  localparam int ACC_W4 = $clog2(MAXW4 * L4 * XLEN + 1);

  typedef struct {
    int res;
    bit act;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic             start_i, in_valid_i, res_ready_i;
  logic [CNT_W-1:0] len_i;
  logic             busy_o, in_ready_o, res_valid_o;
  logic [XLEN-1:0]  op_a_i, op_b_i;
  logic [ACC_W-1:0] res_o;
`ifdef BNN_THRESH_EN
  logic [ACC_W-1:0] thresh_i;
  logic             act_o;
`endif

  logic                start4, in_valid4, res_ready4;
  logic [CNT_W4-1:0]   len4;
  logic                busy4, in_ready4, res_valid4;
  logic [XLEN*L4-1:0]  op_a4, op_b4;
  logic [ACC_W4-1:0]   res4;
`ifdef BNN_THRESH_EN
  logic [ACC_W4-1:0]   thresh4;
  logic                act4;
`endif

  bnn_dot_acc #(.XLEN(XLEN), .LANES(LANES), .MAX_WORDS(MAXW)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
`ifdef BNN_THRESH_EN
    .thresh_i    (thresh_i),
    .act_o       (act_o),
`endif
    .res_o       (res_o)
  );

  bnn_dot_acc #(.XLEN(XLEN), .LANES(L4), .MAX_WORDS(MAXW4)) u_dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start4),
    .len_i       (len4),
    .busy_o      (busy4),
    .in_valid_i  (in_valid4),
    .in_ready_o  (in_ready4),
    .op_a_i      (op_a4),
    .op_b_i      (op_b4),
    .res_valid_o (res_valid4),
    .res_ready_i (res_ready4),
`ifdef BNN_THRESH_EN
    .thresh_i    (thresh4),
    .act_o       (act4),
`endif
    .res_o       (res4)
  );

  exp_t sb[$];
  int   sb4[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d", name, act, act, exp);
    end
  endtask

  // Scoreboard monitor for the single-lane engine.
  always @(negedge clk) begin
    if (res_valid_o === 1'b1 && res_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res_o=%0d, required no result", res_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_o", 32'(res_o), e.res);
`ifdef BNN_THRESH_EN
        check("act_o", 32'(act_o), 32'(e.act));
`endif
      end
    end
  end

  // Scoreboard monitor for the four-lane engine.
  always @(negedge clk) begin
    if (res_valid4 === 1'b1 && res_ready4 === 1'b1) begin
      if (sb4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result4: got res=%0d, required no result", res4);
      end else begin
        int e4;
        e4 = sb4.pop_front();
        check("res4", 32'(res4), e4);
      end
    end
  end

  task automatic expect_res(input int res, input int thr);
    exp_t e;
    e.res = res;
    e.act = (res >= thr);
    sb.push_back(e);
  endtask

  task automatic start_job(input int len, input int thr);
    start_i = 1'b1;
    len_i   = CNT_W'(len);
`ifdef BNN_THRESH_EN
    thresh_i = ACC_W'(thr);
`endif
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Present one beat and hold it until it transfers; bounded wait.
  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    op_a_i = a;
    op_b_i = b;
    while (in_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready_o=%b, required 1 within 20 cycles", in_ready_o);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", 32'(busy_o), 0);
  endtask

  task automatic case2(input int thr);
    expect_res(80, thr);
    start_job(4, thr);
    beat(32'hFFFF_FFFF, 32'h0);
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    beat(32'h0F0F_0F0F, 32'h0);
    beat(32'h0, 32'h0);
    check("case2_valid", 32'(res_valid_o), 1);
    wait_idle();
  endtask

  initial begin
    reset_n = 1'b0;
    start_i = 1'b0; len_i = '0; in_valid_i = 1'b0; res_ready_i = 1'b1;
    op_a_i = '0; op_b_i = '0;
    start4 = 1'b0; len4 = '0; in_valid4 = 1'b0; res_ready4 = 1'b1;
    op_a4 = '0; op_b4 = '0;
`ifdef BNN_THRESH_EN
    thresh_i = '0;
    thresh4  = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_in_ready", 32'(in_ready_o), 0);
    check("rst_res_valid", 32'(res_valid_o), 0);
    check("rst_res", 32'(res_o), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single beat of matching zeros: full word of agreement.
    expect_res(32, 0);
    start_job(1, 0);
    check("t1_busy", 32'(busy_o), 1);
    check("t1_in_ready", 32'(in_ready_o), 1);
    check("t1_no_valid_yet", 32'(res_valid_o), 0);
    beat(32'h0, 32'h0);
    check("t1_valid_cycle2", 32'(res_valid_o), 1);
    check("t1_res", 32'(res_o), 32);
    @(posedge clk); #1;
    check("t1_busy_fall", 32'(busy_o), 0);
    check("t1_valid_fall", 32'(res_valid_o), 0);

    case2(0);
    case2(40);
    case2(81);

    // Gapped input stream; junk data on idle cycles must not count.
    expect_res(76, 0);
    res_ready_i = 1'b0;
    start_job(3, 0);
    in_valid_i = 1'b1; op_a_i = 32'h0; op_b_i = 32'h0;
    @(posedge clk); #1;
    in_valid_i = 1'b0; op_a_i = 32'h123; op_b_i = 32'h123;
    repeat (2) @(posedge clk);
    #1;
    check("t3_still_run", 32'(in_ready_o), 1);
    in_valid_i = 1'b1; op_a_i = 32'h00FF_00FF; op_b_i = 32'h0;
    @(posedge clk); #1;
    op_a_i = 32'h0000_000F;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(res_valid_o), 1);
      check("t3_hold_res", 32'(res_o), 76);
      check("t3_hold_not_ready", 32'(in_ready_o), 0);
      @(posedge clk); #1;
    end
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    wait_idle();

    // Zero-length job goes straight to a zero result.
    expect_res(0, 1);
    start_job(0, 1);
    check("t4_len0_valid", 32'(res_valid_o), 1);
    check("t4_len0_res", 32'(res_o), 0);
    @(posedge clk); #1;
    wait_idle();

    // Starts during RUN, DONE and the DONE handshake are all ignored.
    expect_res(64, 0);
    res_ready_i = 1'b0;
    start_job(2, 0);
    start_i = 1'b1; len_i = CNT_W'(5);
    @(posedge clk); #1;
    start_i = 1'b0;
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    beat(32'hA5A5_A5A5, 32'hA5A5_A5A5);
    check("t4_len_kept", 32'(res_valid_o), 1);
    start_i = 1'b1; len_i = CNT_W'(3);
    @(posedge clk); #1;
    check("t4_done_start_ign", 32'(res_valid_o), 1);
    check("t4_done_res", 32'(res_o), 64);
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("t4_hs_start_ign", 32'(busy_o), 0);

    // Oversized length clamps to the maximum; full-scale result without wrap.
    expect_res(MAXW * LANES * XLEN, 0);
    start_job(100, 0);
    for (int i = 0; i < MAXW; i++) beat(32'h0, 32'h0);
    check("t5_valid", 32'(res_valid_o), 1);
    @(posedge clk); #1;
    wait_idle();

    // Reset mid-job discards everything immediately.
    start_job(3, 0);
    beat(32'h0, 32'h0);
    beat(32'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_in_ready", 32'(in_ready_o), 0);
    check("t6_rst_valid", 32'(res_valid_o), 0);
    check("t6_rst_res", 32'(res_o), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    expect_res(16, 0);
    start_job(1, 0);
    beat(32'hFFFF_0000, 32'h0);
    @(posedge clk); #1;
    wait_idle();

    // Four-lane engine: clamped full-scale job, then per-lane packing.
    sb4.push_back(MAXW4 * L4 * XLEN);
    start4 = 1'b1; len4 = CNT_W4'(15);
    @(posedge clk); #1;
    start4 = 1'b0;
    check("l4_in_ready", 32'(in_ready4), 1);
    in_valid4 = 1'b1; op_a4 = '0; op_b4 = '0;
    repeat (MAXW4) @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    check("l4_valid", 32'(res_valid4), 1);
    check("l4_not_ready", 32'(in_ready4), 0);
    @(posedge clk); #1;
    check("l4_idle", 32'(busy4), 0);
    sb4.push_back(80);
    start4 = 1'b1; len4 = CNT_W4'(1);
    @(posedge clk); #1;
    start4 = 1'b0;
    in_valid4 = 1'b1;
    op_a4 = {32'hFFFF_FFFF, 32'h0, 32'h0000_FFFF, 32'h0};
    op_b4 = '0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("l4_lane_valid", 32'(res_valid4), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 10 && (sb.size() != 0 || sb4.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    check("sb_drained", 32'(sb.size()), 0);
    check("sb4_drained", 32'(sb4.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
